// File: rtl/brs_logic_seq.sv
// ---------------------------------------------------------------------------
// brs_logic_seq
//
// Tiny Tapeout user-module controller around a conditional XOR/AND logic
// unit. Two operand bytes (A, B) are loaded over ui_in under strobes on
// uio_in. A start strobe runs the unit one or more times, feeding each
// result back in as the second operand. The final result is then held on
// uo_out.
//
// Logic function, per bit:
//   f(A,X) = A ^ X   when A[7] = 0
//   f(A,X) = A & X   when A[7] = 1
// Bit 7 of f always equals X[7].
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   design powered (ignored)
//   ui_in    in   [7:0] operand byte on wr_a/wr_b, iteration count on start
//   uio_in   in   [0] wr_a, [1] wr_b, [2] start, [3] clr, [7:4] ignored
//   uo_out   out  [7:0] result register R
//   uio_out  out  [3:0]=0, [4] busy, [5] done, [6] mode (A[7]), [7] err
//   uio_oe   out  constant 8'hF0 (upper nibble driven)
//
// Build option:
//   BRS_ITER_EN  defined   : iteration count sampled from ui_in[CNT_W-1:0]
//                           at start, giving count+1 RUN cycles.
//                undefined : count forced to 0, so every run is exactly one
//                           RUN cycle.
// ---------------------------------------------------------------------------

// One bit of the logic unit. The AND/XOR choice is shared by all lanes.
module brs_logic_lane (
    input  logic a,
    input  logic x,
    input  logic and_mode,
    output logic y
);
    assign y = and_mode ? (a & x) : (a ^ x);
endmodule

module brs_logic_seq #(
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Strobe bundle. Field order matches uio_in[3:0], MSB first.
    typedef struct packed {
        logic clr;
        logic start;
        logic wr_b;
        logic wr_a;
    } strb_t;

    strb_t stb_cur;
    strb_t stb_q;
    strb_t stb_edge;

    logic [1:0]        state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] r_q;
    logic              va_q;
    logic              vb_q;
    logic              err_q;
    logic              first_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_load;

    logic [DATA_W-1:0] x_sel;
    logic [DATA_W-1:0] f_out;
    logic              idle_or_done;

    // ena and the upper uio_in nibble carry no function here.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4]};

    // -----------------------------------------------------------------------
    // Strobe rising-edge detection
    // -----------------------------------------------------------------------
    assign stb_cur  = strb_t'(uio_in[3:0]);
    assign stb_edge = stb_cur & ~stb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stb_q <= '0;
        else        stb_q <= stb_cur;
    end

    // -----------------------------------------------------------------------
    // Iteration count source
    // -----------------------------------------------------------------------
`ifdef BRS_ITER_EN
    assign cnt_load = ui_in[CNT_W-1:0];
`else
    assign cnt_load = '0;
`endif

    // -----------------------------------------------------------------------
    // Logic unit: the first RUN cycle combines A with B, and later cycles
    // combine A with the previous result.
    // -----------------------------------------------------------------------
    assign x_sel = first_q ? b_q : r_q;

    for (genvar i = 0; i < DATA_W; i++) begin : g_lane
        brs_logic_lane u_lane (
            .a        (a_q[i]),
            .x        (x_sel[i]),
            .and_mode (a_q[DATA_W-1]),
            .y        (f_out[i])
        );
    end

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // -----------------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
        end else if (stb_edge.clr) begin
            // clr overrides every other strobe edge in the same cycle.
            // The operands stay, but they must be re-marked valid by new writes.
            state_q <= ST_IDLE;
            r_q     <= '0;
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else if (idle_or_done) begin
            if (stb_edge.wr_a) begin
                a_q  <= ui_in;
                va_q <= 1'b1;
            end
            if (stb_edge.wr_b) begin
                b_q  <= ui_in;
                vb_q <= 1'b1;
            end
            // The valid flags are sampled before this cycle's writes land,
            // so a write in the same cycle as start cannot satisfy start.
            if (stb_edge.start) begin
                if (va_q && vb_q) begin
                    cnt_q   <= cnt_load;
                    err_q   <= 1'b0;
                    first_q <= 1'b1;
                    state_q <= ST_RUN;
                end else begin
                    err_q   <= 1'b1;
                end
            end
        end else if (state_q == ST_RUN) begin
            // Strobes are ignored while running.
            r_q     <= f_out;
            first_q <= 1'b0;
            if (cnt_q == '0) state_q <= ST_DONE;
            else             cnt_q   <= cnt_q - 1'b1;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign uo_out  = r_q;
    assign uio_out = {err_q, a_q[DATA_W-1], (state_q == ST_DONE),
                      (state_q == ST_RUN), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
